// File: rtl/ro_meter_pkg.sv
// ro_meter_pkg: scheduler state encoding and default parameter values
package ro_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        REPORT  = 2'd3
    } state_t;

    localparam int DEF_N_RO       = 4;
    localparam int DEF_SETTLE_CYC = 16;
    localparam int DEF_WIN_CYC    = 1024;
    localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/ro_sync_edge.sv
// ro_sync_edge: 2-flop synchronizer plus history flop, pulses for one clk on each rising edge of d
module ro_sync_edge (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic rise
);

    logic s1, s2, hist;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            hist <= 1'b0;
        end else begin
            s1   <= d;
            s2   <= s1;
            hist <= s2;
        end
    end

    assign rise = s2 & ~hist;

endmodule

// File: rtl/ro_freq_scheduler.sv
// ro_freq_scheduler: enables each ring oscillator in turn, counts its edges over a fixed window, reports via valid/ready
module ro_freq_scheduler
    import ro_meter_pkg::*;
#(
    parameter int N_RO       = DEF_N_RO,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int WIN_CYC    = DEF_WIN_CYC,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start_i,
    input  logic [N_RO-1:0]          ro_clk_i,
    output logic [N_RO-1:0]          ro_en_o,
    output logic                     busy_o,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic [$clog2(N_RO)-1:0]  res_idx_o,
    output logic [CNT_W-1:0]         res_cnt_o,
    output logic                     res_ovf_o,
    output logic                     done_o
);

    localparam int IDX_W = $clog2(N_RO);
    localparam int TMR_W = $clog2((SETTLE_CYC > WIN_CYC ? SETTLE_CYC : WIN_CYC) + 1);
    localparam logic [N_RO-1:0]  ONE     = N_RO'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    logic [TMR_W-1:0]   tmr;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic               ovf;
    logic               ro_sel;
    logic               ro_rise;

    // Disabled oscillators are gated off by their enable, so muxing ahead of the synchronizer is glitch-safe
    assign ro_sel = |(ro_clk_i & ro_en_o);

    ro_sync_edge u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (ro_sel),
        .rise   (ro_rise)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            tmr         <= '0;
            idx         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            ro_en_o     <= '0;
            busy_o      <= 1'b0;
            res_valid_o <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state   <= SETTLE;
                        idx     <= '0;
                        tmr     <= '0;
                        ro_en_o <= ONE;
                        busy_o  <= 1'b1;
                    end
                end
                SETTLE: begin
                    cnt <= '0;
                    ovf <= 1'b0;
                    tmr <= (tmr == TMR_W'(SETTLE_CYC - 1)) ? '0 : tmr + 1'b1;
                    if (tmr == TMR_W'(SETTLE_CYC - 1))
                        state <= MEASURE;
                end
                MEASURE: begin
                    if (ro_rise && cnt == CNT_MAX)
                        ovf <= 1'b1;
                    else if (ro_rise)
                        cnt <= cnt + 1'b1;
                    tmr <= tmr + 1'b1;
                    if (tmr == TMR_W'(WIN_CYC - 1)) begin
                        state       <= REPORT;
                        ro_en_o     <= '0;
                        res_valid_o <= 1'b1;
                    end
                end
                REPORT: begin
                    if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                        tmr         <= '0;
                        if (idx == IDX_W'(N_RO - 1)) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end else begin
                            state   <= SETTLE;
                            idx     <= idx + 1'b1;
                            ro_en_o <= ONE << (idx + 1'b1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign res_idx_o = idx;
    assign res_cnt_o = cnt;
    assign res_ovf_o = ovf;

endmodule

// File: tb/tb_ro_freq_scheduler.sv
// tb_ro_freq_scheduler: directed checks of the oscillator scheduler with 8-bit and 4-bit counter instances
module tb_ro_freq_scheduler;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       ready = 1'b0;
    logic [1:0] ro_clk = 2'b00;

    logic [1:0] en8, en4;
    logic       busy8, busy4, valid8, valid4, idx8, idx4, ovf8, ovf4, done8, done4;
    logic [7:0] cnt8;
    logic [3:0] cnt4;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int per0 = 10, per1 = 10;
    int ph0 = 0, ph1 = 0;

    ro_freq_scheduler #(.N_RO(2), .SETTLE_CYC(4), .WIN_CYC(100), .CNT_W(8)) dut8 (
        .clk(clk), .resetn(resetn), .start_i(start), .ro_clk_i(ro_clk), .ro_en_o(en8),
        .busy_o(busy8), .res_valid_o(valid8), .res_ready_i(ready), .res_idx_o(idx8),
        .res_cnt_o(cnt8), .res_ovf_o(ovf8), .done_o(done8)
    );

    ro_freq_scheduler #(.N_RO(2), .SETTLE_CYC(4), .WIN_CYC(100), .CNT_W(4)) dut4 (
        .clk(clk), .resetn(resetn), .start_i(start), .ro_clk_i(ro_clk), .ro_en_o(en4),
        .busy_o(busy4), .res_valid_o(valid4), .res_ready_i(ready), .res_idx_o(idx4),
        .res_cnt_o(cnt4), .res_ovf_o(ovf4), .done_o(done4)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        ph0 = (ph0 + 1) % per0;
        ph1 = (ph1 + 1) % per1;
        ro_clk[0] = ph0 < per0 / 2;
        ro_clk[1] = ph1 < per1 / 2;
        if (done8) done_cnt++;
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!valid8 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!valid8) begin failures++; $display("FAIL wait_valid timeout got=0 exp=1"); end
    endtask

    task automatic accept();
        ready = 1'b1;
        @(negedge clk) ready = 1'b0;
    endtask

    task automatic check_res(input string nm, input int i, input int c, input int o);
        checks++;
        if ({idx8, cnt8, ovf8} !== {i[0], c[7:0], o[0]}) begin
            failures++;
            $display("FAIL %s got idx=%0d cnt=%0d ovf=%0d exp idx=%0d cnt=%0d ovf=%0d", nm, idx8, cnt8, ovf8, i, c, o);
        end
    endtask

    task automatic check_zero(input string nm);
        checks++;
        if ({en8, busy8, valid8, idx8, cnt8, ovf8, done8} !== '0) begin
            failures++;
            $display("FAIL %s dut8 en=%b busy=%b valid=%b idx=%0d cnt=%0d ovf=%b done=%b exp all 0", nm, en8, busy8, valid8, idx8, cnt8, ovf8, done8);
        end
        checks++;
        if ({en4, busy4, valid4, idx4, cnt4, ovf4, done4} !== '0) begin
            failures++;
            $display("FAIL %s dut4 en=%b busy=%b valid=%b idx=%0d cnt=%0d ovf=%b done=%b exp all 0", nm, en4, busy4, valid4, idx4, cnt4, ovf4, done4);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset_outputs");
        resetn = 1'b1;
        @(negedge clk);
        check_zero("idle_after_reset");
    endtask

    task automatic test_basic();
        int n, d0;
        per0 = 10; per1 = 10;
        d0 = done_cnt;
        pulse_start();
        checks++;
        if (en8 !== 2'b01 || busy8 !== 1'b1) begin failures++; $display("FAIL settle_en got en=%b busy=%b exp en=01 busy=1", en8, busy8); end
        wait_valid(n);
        check_res("basic_res0", 0, 10, 0);
        checks++;
        if (en8 !== 2'b00) begin failures++; $display("FAIL report_en got=%b exp=00", en8); end
        accept();
        checks++;
        if (en8 !== 2'b10 || valid8 !== 1'b0) begin failures++; $display("FAIL settle1_en got en=%b valid=%b exp en=10 valid=0", en8, valid8); end
        wait_valid(n);
        check_res("basic_res1", 1, 10, 0);
        checks++;
        if (done_cnt !== d0) begin failures++; $display("FAIL early_done got=%0d exp=%0d", done_cnt, d0); end
        accept();
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt !== d0 + 1 || busy8 !== 1'b0) begin failures++; $display("FAIL basic_done got done=%0d busy=%b exp done=%0d busy=0", done_cnt - d0, busy8, 1); end
    endtask

    task automatic test_rate4();
        int n;
        per0 = 10; per1 = 4;
        pulse_start();
        wait_valid(n);
        checks++;
        if (n + 1 !== 105) begin failures++; $display("FAIL first_valid_latency got=%0d exp=105", n + 1); end
        check_res("rate4_res0", 0, 10, 0);
        checks++;
        if ({cnt4, ovf4} !== {4'd10, 1'b0}) begin failures++; $display("FAIL w4_res0 got cnt=%0d ovf=%b exp cnt=10 ovf=0", cnt4, ovf4); end
        accept();
        wait_valid(n);
        check_res("rate4_res1", 1, 25, 0);
        checks++;
        if ({valid4, idx4, cnt4, ovf4} !== {1'b1, 1'b1, 4'd15, 1'b1}) begin failures++; $display("FAIL w4_saturate got valid=%b idx=%0d cnt=%0d ovf=%b exp valid=1 idx=1 cnt=15 ovf=1", valid4, idx4, cnt4, ovf4); end
        accept();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_stall();
        int n, bad;
        per0 = 10; per1 = 4;
        pulse_start();
        wait_valid(n);
        accept();
        wait_valid(n);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!valid8 || idx8 !== 1'b1 || cnt8 !== 8'd25 || en8 !== 2'b00 || !busy8) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL stall_stable got bad_cycles=%0d exp=0", bad); end
        check_res("stall_res1", 1, 25, 0);
        accept();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n, d0, busy_cycles;
        per0 = 10; per1 = 10;
        d0 = done_cnt;
        pulse_start();
        repeat (30) @(negedge clk);
        pulse_start();
        wait_valid(n);
        check_res("b2b_res0", 0, 10, 0);
        accept();
        wait_valid(n);
        accept();
        busy_cycles = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy8) busy_cycles++;
        end
        checks++;
        if (done_cnt !== d0 + 1 || busy_cycles !== 0) begin failures++; $display("FAIL start_not_queued got done=%0d busy_cycles=%0d exp done=1 busy_cycles=0", done_cnt - d0, busy_cycles); end
    endtask

    task automatic test_abort();
        int n, d0, act;
        per0 = 10; per1 = 10;
        d0 = done_cnt;
        pulse_start();
        repeat (20) @(negedge clk);
        pulse_start();
        wait_valid(n);
        accept();
        checks++;
        if (en8 !== 2'b10) begin failures++; $display("FAIL abort_pre_settle got en=%b exp=10", en8); end
        resetn = 1'b0;
        @(negedge clk) resetn = 1'b1;
        check_zero("abort_outputs");
        act = 0;
        repeat (300) begin
            @(negedge clk);
            if (busy8 || valid8 || en8 !== 2'b00) act++;
        end
        checks++;
        if (done_cnt !== d0 || act !== 0) begin failures++; $display("FAIL abort_quiet got done=%0d active_cycles=%0d exp done=0 active_cycles=0", done_cnt - d0, act); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rate4();
        test_stall();
        test_back_to_back();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
